// File: rtl/dcim_pkg.sv
// Shared FSM encoding and saturating arithmetic for the compute-in-memory MAC.
// The adder works at a fixed wide width so that any legal accumulator width fits.
package dcim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    ovf;
    } sat_t;

    // Sign-extended operands in; the sum comes back clamped to an acc_w-bit signed range.
    function automatic sat_t sat_add(input logic signed [SAT_W-1:0] a,
                                     input logic signed [SAT_W-1:0] b,
                                     input int unsigned             acc_w);
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sat_t                  r;
        s     = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi    = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
        lo    = -(65'sd1 <<< (acc_w - 1));
        r.sum = s[SAT_W-1:0];
        r.ovf = 1'b0;
        if (s > hi) begin
            r.sum = hi[SAT_W-1:0];
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.sum = lo[SAT_W-1:0];
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dcim_sram_array.sv
// Weight storage: masked write port, registered read port with a one-cycle
// valid, and an unregistered row tap feeding the MAC datapath.
module dcim_sram_array
    import dcim_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [ADDR_W-1:0] mac_addr,
    output logic [DATA_W-1:0] mac_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] row_d;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              rd_valid_d, rd_valid_q;

    always_comb begin
        row_d      = (wr_data & wr_mask) | (mem_q[wr_addr] & ~wr_mask);
        rd_data_d  = rd_en ? mem_q[rd_addr] : rd_data_q;
        rd_valid_d = rd_en;
    end

    // Contents survive reset; only the read-side registers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign mac_data = mem_q[mac_addr];

endmodule

// File: rtl/dcim_sram_mac.sv
// SRAM with an attached dot-product engine: a MAC command walks mac_len rows
// from mac_base (wrapping), multiplying each by one streamed activation.
module dcim_sram_mac
    import dcim_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int ACT_W  = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_in,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wd_in,
    input  logic [DATA_W-1:0] bm_in,
    output logic [DATA_W-1:0] rd_out,
    output logic              rd_valid,
    input  logic              mac_start,
    input  logic [ADDR_W-1:0] mac_base,
    input  logic [ADDR_W:0]   mac_len,
    input  logic [ACT_W-1:0]  act_in,
    input  logic              act_valid,
    output logic              act_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              acc_ovf,
    output logic              busy
);

    state_e                          state_q, state_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic signed [ACC_W-1:0]         acc_out_q, acc_out_d;
    logic [ADDR_W-1:0]               ptr_q, ptr_d;
    logic [ADDR_W:0]                 cnt_q, cnt_d;
    logic                            ovf_q, ovf_d;
    logic                            port_en, mem_wr, mem_rd;
    logic [DATA_W-1:0]               mac_row;
    logic signed [DATA_W+ACT_W-1:0]  prod;
    logic signed [ACC_W-1:0]         acc_next;
    sat_t                            sum;

    // The memory port is only live in IDLE, and a same-cycle mac_start wins.
    assign port_en = (state_q == ST_IDLE) & ~mac_start & ~ce_in & ~rst;
    assign mem_wr  = port_en & ~we_in;
    assign mem_rd  = port_en & we_in;

    dcim_sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (mem_wr),
        .wr_addr  (addr_in),
        .wr_data  (wd_in),
        .wr_mask  (bm_in),
        .rd_en    (mem_rd),
        .rd_addr  (addr_in),
        .rd_data  (rd_out),
        .rd_valid (rd_valid),
        .mac_addr (ptr_q),
        .mac_data (mac_row)
    );

    assign prod     = $signed(act_in) * $signed(mac_row);
    assign sum      = sat_add(SAT_W'(prod), SAT_W'(acc_q), ACC_W);
    assign acc_next = ACC_W'(sum.sum);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (mac_start) begin
                    acc_d = '0;
                    ptr_d = mac_base;
                    cnt_d = mac_len;
                    ovf_d = 1'b0;
                    if (mac_len == '0) begin
                        state_d   = ST_DONE;
                        acc_out_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (act_valid) begin
                    acc_d = acc_next;
                    ovf_d = ovf_q | sum.ovf;
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == (ADDR_W+1)'(1)) begin
                        state_d   = ST_DONE;
                        acc_out_d = acc_next;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            acc_out_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign act_ready = (state_q == ST_RUN);
    assign acc_valid = (state_q == ST_DONE);
    assign acc_out   = acc_out_q;
    assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_dcim_sram_mac.sv
// Directed bench: default-width instance plus a 16-bit accumulator instance
// sharing the same stimulus, to exercise saturation.
module tb_dcim_sram_mac;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int XW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce_in = 1'b1, we_in = 1'b1, mac_start = 1'b0, act_valid = 1'b0;
    logic [AW-1:0] addr_in = '0, mac_base = '0;
    logic [DW-1:0] wd_in = '0, bm_in = '0;
    logic [AW:0]   mac_len = '0;
    logic [XW-1:0] act_in = '0;

    logic [DW-1:0] rd_out, rd_out16;
    logic          rd_valid, rd_valid16;
    logic [23:0]   acc_out;
    logic [15:0]   acc_out16;
    logic          acc_valid, acc_valid16, acc_ovf, acc_ovf16;
    logic          busy, busy16, act_ready, act_ready16;

    int errs = 0;
    int checks = 0;
    int acts[8];
    bit vlds[8];

    always #5 clk = ~clk;

    dcim_sram_mac u_dut (
        .clk(clk), .rst(rst), .ce_in(ce_in), .we_in(we_in), .addr_in(addr_in),
        .wd_in(wd_in), .bm_in(bm_in), .rd_out(rd_out), .rd_valid(rd_valid),
        .mac_start(mac_start), .mac_base(mac_base), .mac_len(mac_len),
        .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ovf(acc_ovf), .busy(busy)
    );

    dcim_sram_mac #(.ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .ce_in(ce_in), .we_in(we_in), .addr_in(addr_in),
        .wd_in(wd_in), .bm_in(bm_in), .rd_out(rd_out16), .rd_valid(rd_valid16),
        .mac_start(mac_start), .mac_base(mac_base), .mac_len(mac_len),
        .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready16),
        .acc_out(acc_out16), .acc_valid(acc_valid16), .acc_ovf(acc_ovf16), .busy(busy16)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d, input int m);
        ce_in = 1'b0; we_in = 1'b0; addr_in = AW'(a); wd_in = DW'(d); bm_in = DW'(m);
        tick();
        ce_in = 1'b1; we_in = 1'b1;
    endtask

    task automatic rd(input int a, input int exp, input string tag);
        ce_in = 1'b0; we_in = 1'b1; addr_in = AW'(a);
        tick();
        ce_in = 1'b1;
        chk({tag, "_vld"}, rd_valid, 1);
        chk({tag, "_vld16"}, rd_valid16, 1);
        chk({tag, "_data"}, rd_out, exp);
        chk({tag, "_data16"}, rd_out16, exp);
        tick();
        chk({tag, "_vld_off"}, rd_valid, 0);
        chk({tag, "_hold"}, rd_out, exp);
    endtask

    // Drives n activation slots from acts/vlds, then expects acc_valid right after slot n.
    task automatic mac_run(input string tag, input int base, input int len, input int n,
                           input int e_acc, input int e_acc16, input int e_ovf, input int e_ovf16);
        int k = 0;
        bit seen = 1'b0;
        mac_base = AW'(base); mac_len = (AW+1)'(len); mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        if (len > 0) begin
            chk({tag, "_ready"}, act_ready, 1);
            chk({tag, "_ready16"}, act_ready16, 1);
        end
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            if (acc_valid) begin
                seen = 1'b1;
            end else begin
                act_valid = (k < n) ? vlds[k] : 1'b0;
                act_in    = (k < n) ? XW'(acts[k]) : '0;
                if (k < n) k++;
                tick();
            end
        end
        act_valid = 1'b0;
        chk({tag, "_seen"}, seen, 1);
        chk({tag, "_lat"}, k, n);
        chk({tag, "_vld16"}, acc_valid16, 1);
        chk({tag, "_acc"}, $signed(acc_out), e_acc);
        chk({tag, "_acc16"}, $signed(acc_out16), e_acc16);
        chk({tag, "_ovf"}, acc_ovf, e_ovf);
        chk({tag, "_ovf16"}, acc_ovf16, e_ovf16);
        chk({tag, "_done_rdy"}, act_ready, 0);
        tick();
        chk({tag, "_vld_off"}, acc_valid, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_acc_hold"}, $signed(acc_out), e_acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_ovf", acc_ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", act_ready, 0);
        rst = 1'b0;

        // Masked write merges new low nibble into old high nibble.
        wr(3, 'h5A, 'hFF);
        wr(3, 'hFF, 'h0F);
        rd(3, 'h5F, "mask");

        wr(0, 'h01, 'hFF); wr(1, 'hFE, 'hFF); wr(2, 'h03, 'hFF); wr(3, 'h04, 'hFF);
        acts = '{2, 2, 2, 2, 0, 0, 0, 0};
        vlds = '{1, 1, 1, 1, 0, 0, 0, 0};
        mac_run("mac4", 0, 4, 4, 12, 12, 0, 0);

        wr(14, 1, 'hFF); wr(15, 1, 'hFF); wr(0, 1, 'hFF); wr(1, 1, 'hFF);
        acts = '{1, 1, 1, 1, 0, 0, 0, 0};
        mac_run("wrap", 14, 4, 4, 4, 4, 0, 0);

        // Rows 0..3 are now 1,1,3,4: 5*1 + -1*1 + 2*3 + 3*4 = 22.
        acts = '{5, 99, 99, -1, 2, 99, 3, 0};
        vlds = '{1, 0, 0, 1, 1, 0, 1, 0};
        mac_run("gaps", 0, 4, 7, 22, 22, 0, 0);

        wr(4, 'h80, 'hFF); wr(5, 'h80, 'hFF); wr(6, 'h80, 'hFF); wr(7, 'h80, 'hFF);
        acts = '{-128, -128, -128, -128, 0, 0, 0, 0};
        vlds = '{1, 1, 1, 1, 0, 0, 0, 0};
        mac_run("satp", 4, 4, 4, 65536, 32767, 0, 1);

        wr(8, 'h7F, 'hFF); wr(9, 'h7F, 'hFF); wr(10, 'h7F, 'hFF);
        acts = '{-128, -128, -128, 0, 0, 0, 0, 0};
        vlds = '{1, 1, 1, 0, 0, 0, 0, 0};
        mac_run("satn", 8, 3, 3, -48768, -32768, 0, 1);

        // Abort after two handshakes; port traffic and mac_start in RUN are ignored.
        mac_base = '0; mac_len = 5'd4; mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        act_valid = 1'b1; act_in = 8'd1;
        tick();
        tick();
        act_valid = 1'b0;
        chk("abort_ovf_clr16", acc_ovf16, 0);
        ce_in = 1'b0; we_in = 1'b0; addr_in = 4'd3; wd_in = 8'h77; bm_in = 8'hFF;
        mac_start = 1'b1; mac_len = '0;
        tick();
        ce_in = 1'b1; we_in = 1'b1; mac_start = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_ready", act_ready, 1);
        ce_in = 1'b0; we_in = 1'b1; addr_in = 4'd3;
        tick();
        ce_in = 1'b1;
        chk("run_no_rd", rd_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_busy16", busy16, 0);
        chk("abort_ready", act_ready, 0);
        chk("abort_acc_valid", acc_valid, 0);
        chk("abort_acc_out", acc_out, 0);
        chk("abort_rd_out", rd_out, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_pulse", acc_valid, 0);
        end
        rd(3, 'h04, "post_rst3");
        rd(1, 'h01, "post_rst1");

        mac_run("len0", 5, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
